// File: rtl/pl_col_scan_ctrl_pkg.sv
// pl_scan_pkg: shared widths, FSM states and scan configuration type for the column scan sequencer.
package pl_scan_pkg;

    localparam int COL_W  = 10;
    localparam int DATA_W = 36;
    localparam int ADDR_W = 10;

    // Column 0 is the broadcast/OR select; idling on it keeps the chain output at zero.
    localparam logic [COL_W-1:0] PL_COL_BCAST = 10'h000;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, OUT, DONE} state_t;

    typedef struct packed {
        logic [COL_W-1:0]  start_col;
        logic [COL_W-1:0]  num_cols;
        logic [ADDR_W:0]   depth;
    } cfg_t;

endpackage

// File: rtl/pl_col_scan_ctrl_if.sv
// pl_col_scan_ctrl_if: request, chain and consumer signals of the column scan sequencer.
interface pl_col_scan_ctrl_if;
    import pl_scan_pkg::*;

    logic              START_i;
    logic              ABORT_i;
    logic [COL_W-1:0]  START_COL_i;
    logic [COL_W-1:0]  NUM_COLS_i;
    logic [ADDR_W:0]   DEPTH_i;
    logic [DATA_W-1:0] CHAIN_DATA_i;
    logic              READY_i;
    logic [COL_W-1:0]  PL_COL_o;
    logic [ADDR_W-1:0] RD_ADDR_o;
    logic              RD_EN_o;
    logic [DATA_W-1:0] DATA_o;
    logic [COL_W-1:0]  COL_o;
    logic [ADDR_W-1:0] ADDR_o;
    logic              VALID_o;
    logic              BUSY_o;
    logic              DONE_o;
    logic              ERR_o;

    modport master (
        output START_i, ABORT_i, START_COL_i, NUM_COLS_i, DEPTH_i, CHAIN_DATA_i, READY_i,
        input  PL_COL_o, RD_ADDR_o, RD_EN_o, DATA_o, COL_o, ADDR_o, VALID_o, BUSY_o, DONE_o, ERR_o
    );

    modport slave (
        input  START_i, ABORT_i, START_COL_i, NUM_COLS_i, DEPTH_i, CHAIN_DATA_i, READY_i,
        output PL_COL_o, RD_ADDR_o, RD_EN_o, DATA_o, COL_o, ADDR_o, VALID_o, BUSY_o, DONE_o, ERR_o
    );

endinterface

// File: rtl/pl_col_scan_ctrl_cursor.sv
// pl_scan_cursor: column/row cursor with row wrap, last-word flag and start-config legality check.
module pl_scan_cursor
    import pl_scan_pkg::*;
(
    input  logic              CLK_i,
    input  logic              RESETn_i,
    input  logic              load,
    input  logic              adv,
    input  cfg_t              cfg,
    output logic [COL_W-1:0]  col,
    output logic [ADDR_W-1:0] addr,
    output logic [COL_W-1:0]  nxt_col,
    output logic [ADDR_W-1:0] nxt_addr,
    output logic              last,
    output logic              legal
);

    cfg_t              cfg_q, cfg_d;
    logic [COL_W-1:0]  col_q, col_d, last_col;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [COL_W:0]    end_col;
    logic              addr_wrap;

    always_comb begin
        // End column computed one bit wider so a range running past the top ID shows up as a carry.
        end_col   = {1'b0, cfg.start_col} + {1'b0, cfg.num_cols} - (COL_W+1)'(1);
        legal     = cfg.start_col != PL_COL_BCAST && cfg.num_cols != '0 && cfg.depth != '0 &&
                    !(cfg.depth[ADDR_W] && |cfg.depth[ADDR_W-1:0]) && !end_col[COL_W];
        last_col  = cfg_q.start_col + cfg_q.num_cols - COL_W'(1);
        addr_wrap = {1'b0, addr_q} == cfg_q.depth - (ADDR_W+1)'(1);
        nxt_addr  = addr_wrap ? '0 : addr_q + ADDR_W'(1);
        nxt_col   = addr_wrap ? col_q + COL_W'(1) : col_q;
        last      = addr_wrap && col_q == last_col;
        cfg_d     = load ? cfg : cfg_q;
        col_d     = load ? cfg.start_col : adv ? nxt_col : col_q;
        addr_d    = load ? '0 : adv ? nxt_addr : addr_q;
    end

    always_ff @(posedge CLK_i or negedge RESETn_i) begin
        if (!RESETn_i) begin
            cfg_q  <= '0;
            col_q  <= '0;
            addr_q <= '0;
        end else begin
            cfg_q  <= cfg_d;
            col_q  <= col_d;
            addr_q <= addr_d;
        end
    end

    assign col  = col_q;
    assign addr = addr_q;

endmodule

// File: rtl/pl_col_scan_ctrl.sv
// pl_col_scan_ctrl: walks a column range, strobes each row, waits the chain latency and
// hands every captured word to the consumer over valid/ready. All outputs are registered.
module pl_col_scan_ctrl
    import pl_scan_pkg::*;
#(
    parameter int CHAIN_LAT = 2
)
(
    input  logic              CLK_i,
    input  logic              RESETn_i,
    pl_col_scan_ctrl_if.slave bus
);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [COL_W-1:0]  pl_col_q, pl_col_d, col_tag_q, col_tag_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d, addr_tag_q, addr_tag_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              rd_en_q, rd_en_d, valid_q, valid_d, busy_q, busy_d;
    logic              done_q, done_d, err_q, err_d;
    logic              load, adv, last, legal;
    logic [COL_W-1:0]  cur_col, nxt_col;
    logic [ADDR_W-1:0] cur_addr, nxt_addr;
    cfg_t              start_cfg;

    assign start_cfg = '{start_col: bus.START_COL_i, num_cols: bus.NUM_COLS_i, depth: bus.DEPTH_i};

    pl_scan_cursor u_cursor (
        .CLK_i    (CLK_i),
        .RESETn_i (RESETn_i),
        .load     (load),
        .adv      (adv),
        .cfg      (start_cfg),
        .col      (cur_col),
        .addr     (cur_addr),
        .nxt_col  (nxt_col),
        .nxt_addr (nxt_addr),
        .last     (last),
        .legal    (legal)
    );

    // Outputs are decoded from the next state so each one is valid for exactly the cycle the FSM sits there.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pl_col_d   = pl_col_q;
        rd_addr_d  = rd_addr_q;
        rd_en_d    = 1'b0;
        data_d     = data_q;
        col_tag_d  = col_tag_q;
        addr_tag_d = addr_tag_q;
        valid_d    = valid_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        load       = 1'b0;
        adv        = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.START_i && legal) begin
                    load      = 1'b1;
                    state_d   = ISSUE;
                    pl_col_d  = bus.START_COL_i;
                    rd_addr_d = '0;
                    rd_en_d   = 1'b1;
                    busy_d    = 1'b1;
                end else begin
                    err_d = bus.START_i;
                end
            end
            ISSUE: begin
                state_d = WAIT;
                cnt_d   = 4'(CHAIN_LAT - 1);
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d    = OUT;
                    data_d     = bus.CHAIN_DATA_i;
                    col_tag_d  = cur_col;
                    addr_tag_d = cur_addr;
                    valid_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            OUT: begin
                if (bus.READY_i) begin
                    adv       = 1'b1;
                    valid_d   = 1'b0;
                    state_d   = last ? DONE : ISSUE;
                    done_d    = last;
                    rd_en_d   = !last;
                    pl_col_d  = last ? PL_COL_BCAST : nxt_col;
                    rd_addr_d = last ? rd_addr_q : nxt_addr;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        // Abort overrides acceptance and a same-cycle start; any pending word is dropped.
        if (bus.ABORT_i) begin
            state_d  = IDLE;
            pl_col_d = PL_COL_BCAST;
            rd_en_d  = 1'b0;
            valid_d  = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b0;
            err_d    = 1'b0;
            load     = 1'b0;
            adv      = 1'b0;
        end
    end

    always_ff @(posedge CLK_i or negedge RESETn_i) begin
        if (!RESETn_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            pl_col_q   <= PL_COL_BCAST;
            rd_addr_q  <= '0;
            rd_en_q    <= 1'b0;
            data_q     <= '0;
            col_tag_q  <= '0;
            addr_tag_q <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pl_col_q   <= pl_col_d;
            rd_addr_q  <= rd_addr_d;
            rd_en_q    <= rd_en_d;
            data_q     <= data_d;
            col_tag_q  <= col_tag_d;
            addr_tag_q <= addr_tag_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign bus.PL_COL_o  = pl_col_q;
    assign bus.RD_ADDR_o = rd_addr_q;
    assign bus.RD_EN_o   = rd_en_q;
    assign bus.DATA_o    = data_q;
    assign bus.COL_o     = col_tag_q;
    assign bus.ADDR_o    = addr_tag_q;
    assign bus.VALID_o   = valid_q;
    assign bus.BUSY_o    = busy_q;
    assign bus.DONE_o    = done_q;
    assign bus.ERR_o     = err_q;

endmodule

// File: tb/tb_pl_col_scan_ctrl.sv
// tb_pl_col_scan_ctrl: directed checks of the column scan sequencer at chain latency 2 and 1.
module tb_pl_col_scan_ctrl;
    import pl_scan_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_chk = 0;
    int   n_pass = 0;

    pl_col_scan_ctrl_if a();
    pl_col_scan_ctrl_if b();

    pl_col_scan_ctrl #(.CHAIN_LAT(2)) dut_a (.CLK_i(clk), .RESETn_i(rst_n), .bus(a));
    pl_col_scan_ctrl #(.CHAIN_LAT(1)) dut_b (.CLK_i(clk), .RESETn_i(rst_n), .bus(b));

    always #5 clk = ~clk;

    // Chain model: the word {col,addr} is stable only CHAIN_LAT cycles after the strobe, garbage otherwise.
    logic [35:0] pa0, pa1, pb0;
    always @(posedge clk) begin
        pa0 <= a.RD_EN_o ? {16'h0, a.PL_COL_o, a.RD_ADDR_o} : 36'hF_DEAD_BEEF;
        pa1 <= pa0;
        pb0 <= b.RD_EN_o ? {16'h0, b.PL_COL_o, b.RD_ADDR_o} : 36'hF_DEAD_BEEF;
    end
    assign a.CHAIN_DATA_i = pa1;
    assign b.CHAIN_DATA_i = pb0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_a(input logic [9:0] c, input logic [9:0] n, input logic [10:0] d);
        a.START_COL_i = c;
        a.NUM_COLS_i  = n;
        a.DEPTH_i     = d;
        a.START_i     = 1'b1;
        tick();
        a.START_i     = 1'b0;
    endtask

    // Runs the (3,2,2) scan already started on dut_a; optionally stalls the second word.
    task automatic scan_a(input int stall);
        int t = 0, w = 0, st = 0, dones = 0, done_t = -1, badpl = 0, rdens = 0, hold_bad = 0, stall_rd = 0;
        logic [35:0] held = '0;
        int          acc_t[4];
        logic [55:0] acc_w[4];
        while (t < 80 && (t == 0 || a.BUSY_o)) begin
            if (a.BUSY_o && !a.DONE_o && a.PL_COL_o == '0) badpl++;
            if (a.DONE_o) begin dones++; done_t = t; end
            if (a.RD_EN_o) rdens++;
            a.READY_i = 1'b1;
            if (a.VALID_o) begin
                if (w == 1 && st < stall) begin
                    if (st == 0) held = a.DATA_o;
                    else if (a.DATA_o != held || a.COL_o != 10'd3 || a.ADDR_o != 10'd1) hold_bad++;
                    if (a.RD_EN_o) stall_rd++;
                    a.READY_i = 1'b0;
                    st++;
                end else begin
                    if (w < 4) begin acc_t[w] = t; acc_w[w] = {a.COL_o, a.ADDR_o, a.DATA_o}; end
                    w++;
                end
            end
            tick();
            t++;
        end
        a.READY_i = 1'b1;
        chk("scan_idle", 64'(a.BUSY_o), 64'(0));
        chk("word_count", 64'(w), 64'(4));
        for (int k = 0; k < 4; k++) begin
            logic [9:0] c = 10'(3 + k / 2);
            logic [9:0] r = 10'(k % 2);
            chk($sformatf("word%0d", k), 64'(acc_w[k]), 64'({c, r, 16'h0, c, r}));
            chk($sformatf("word%0d_t", k), 64'(acc_t[k]), 64'(3 + 4 * k + (k >= 1 ? stall : 0)));
        end
        chk("done_pulses", 64'(dones), 64'(1));
        chk("done_t", 64'(done_t), 64'(16 + stall));
        chk("pl_col_nonzero", 64'(badpl), 64'(0));
        chk("rd_en_count", 64'(rdens), 64'(4));
        if (stall > 0) begin
            chk("stall_len", 64'(st), 64'(stall));
            chk("stall_hold", 64'(hold_bad), 64'(0));
            chk("stall_rd_en", 64'(stall_rd), 64'(0));
        end
    endtask

    initial begin
        a.START_i = 0; a.ABORT_i = 0; a.START_COL_i = 0; a.NUM_COLS_i = 0; a.DEPTH_i = 0; a.READY_i = 1;
        b.START_i = 0; b.ABORT_i = 0; b.START_COL_i = 0; b.NUM_COLS_i = 0; b.DEPTH_i = 0; b.READY_i = 1;
        #2 rst_n = 1'b0;
        repeat (2) tick();
        chk("rst_outs", 64'({a.PL_COL_o, a.RD_ADDR_o, a.RD_EN_o, a.VALID_o, a.BUSY_o, a.DONE_o, a.ERR_o}), 64'(0));
        chk("rst_tags", 64'({a.COL_o, a.ADDR_o}), 64'(0));
        chk("rst_data", 64'(a.DATA_o), 64'(0));
        rst_n = 1'b1;
        tick();

        // Basic scan, then the same scan with the second word stalled 5 cycles.
        start_a(10'd3, 10'd2, 11'd2);
        chk("issue_col", 64'(a.PL_COL_o), 64'(3));
        chk("issue_en", 64'(a.RD_EN_o), 64'(1));
        scan_a(0);
        tick();
        start_a(10'd3, 10'd2, 11'd2);
        scan_a(5);
        tick();

        // Illegal configurations: start on broadcast column, range past the top ID, depth too large.
        for (int i = 0; i < 3; i++) begin
            logic [9:0]  c = (i == 0) ? 10'd0 : (i == 1) ? 10'd1020 : 10'd1;
            logic [9:0]  n = (i == 1) ? 10'd5 : 10'd1;
            logic [10:0] d = (i == 2) ? 11'd1025 : 11'd1;
            start_a(c, n, d);
            chk($sformatf("err%0d", i), 64'({a.ERR_o, a.BUSY_o, a.RD_EN_o}), 64'(3'b100));
            tick();
            chk($sformatf("err%0d_pulse", i), 64'({a.ERR_o, a.BUSY_o, a.RD_EN_o}), 64'(0));
        end

        // Top-of-range legal scan: columns 1020..1023, one row each.
        start_a(10'd1020, 10'd4, 11'd1);
        chk("edge_legal", 64'({a.ERR_o, a.BUSY_o, a.PL_COL_o}), 64'({1'b0, 1'b1, 10'd1020}));
        for (int i = 0; i < 40 && a.BUSY_o; i++) tick();
        chk("edge_finish", 64'(a.BUSY_o), 64'(0));
        tick();

        // Abort in the WAIT of the third word, then restart.
        start_a(10'd3, 10'd2, 11'd2);
        repeat (8) tick();
        chk("third_issue", 64'({a.RD_EN_o, a.PL_COL_o, a.RD_ADDR_o}), 64'({1'b1, 10'd4, 10'd0}));
        tick();
        chk("third_wait", 64'({a.RD_EN_o, a.VALID_o, a.BUSY_o}), 64'(3'b001));
        a.ABORT_i = 1'b1;
        tick();
        a.ABORT_i = 1'b0;
        chk("abort_state", 64'({a.BUSY_o, a.PL_COL_o, a.VALID_o, a.RD_EN_o, a.DONE_o}), 64'(0));
        begin
            int act = 0;
            repeat (6) begin tick(); act += int'(a.DONE_o) + int'(a.VALID_o) + int'(a.RD_EN_o); end
            chk("abort_quiet", 64'(act), 64'(0));
        end
        start_a(10'd3, 10'd2, 11'd2);
        chk("restart", 64'({a.PL_COL_o, a.RD_ADDR_o, a.RD_EN_o}), 64'({10'd3, 10'd0, 1'b1}));
        scan_a(0);
        tick();

        // Asynchronous reset while a word waits in OUT.
        start_a(10'd3, 10'd2, 11'd2);
        a.READY_i = 1'b0;
        repeat (3) tick();
        chk("pre_rst_valid", 64'(a.VALID_o), 64'(1));
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst", 64'({a.PL_COL_o, a.RD_ADDR_o, a.RD_EN_o, a.VALID_o, a.BUSY_o, a.DONE_o, a.ERR_o}), 64'(0));
        chk("async_rst_word", 64'({a.COL_o, a.ADDR_o, a.DATA_o}), 64'(0));
        a.READY_i = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();

        // Full-depth column at chain latency 1.
        b.START_COL_i = 10'd7;
        b.NUM_COLS_i  = 10'd1;
        b.DEPTH_i     = 11'd1024;
        b.START_i     = 1'b1;
        tick();
        b.START_i     = 1'b0;
        begin
            int t = 0, w = 0, bad = 0, done_t = -1, last_addr = -1;
            while (t < 4000 && (t == 0 || b.BUSY_o)) begin
                if (b.VALID_o) begin
                    if (b.ADDR_o != 10'(w) || b.COL_o != 10'd7 ||
                        b.DATA_o != {16'h0, 10'd7, 10'(w)} || t != 2 + 3 * w) bad++;
                    last_addr = int'(b.ADDR_o);
                    w++;
                end
                if (b.DONE_o) done_t = t;
                tick();
                t++;
            end
            chk("deep_words", 64'(w), 64'(1024));
            chk("deep_seq", 64'(bad), 64'(0));
            chk("deep_last", 64'(last_addr), 64'(1023));
            chk("deep_done_t", 64'(done_t), 64'(3072));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
